muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_pkg.sv | 28 ++
 rtl/muldiv_unit.sv | 204 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared configuration for the M-extension multiply/divide unit.
// Holds the funct3 op encodings, the FSM state encoding and the default
// ROB tag width, so every user of the unit agrees on them.
package muldiv_unit_pkg;

   localparam int ROB_SIZE_BIT = 4;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // funct3[2] separates the divide family from the multiply family.
   function automatic logic is_div_op(input logic [2:0] f);
      return f[2];
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit.
// One radix-2 step per enabled cycle on operand magnitudes; the sign of the
// result is applied on the final step. Multiply and divide share a single
// 2*XLEN shift register and one XLEN+1 bit adder.
//
// Ports:
//   clk_in      system clock, rising edge
//   rst_n_in    asynchronous active-low reset
//   rdy_in      global ready, low freezes all state
//   rob_clear   flush, discards any in-flight operation
//   in_valid    operation offered
//   in_ready    unit can accept (IDLE only)
//   op          funct3 operation code
//   r1_val      rs1 operand
//   r2_val      rs2 operand
//   in_rob_id   tag of the offered instruction
//   out_valid   result available (DONE)
//   out_ready   consumer takes the result
//   out_rob_id  tag of the result
//   out_res     result value
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ROB_ID_W = ROB_SIZE_BIT
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                rdy_in,
   input  logic                rob_clear,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          op,
   input  logic [XLEN-1:0]     r1_val,
   input  logic [XLEN-1:0]     r2_val,
   input  logic [ROB_ID_W-1:0] in_rob_id,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ROB_ID_W-1:0] out_rob_id,
   output logic [XLEN-1:0]     out_res
);

   localparam int               CNT_W = $clog2(XLEN) + 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(XLEN - 1);

   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                                input logic            n);
      return n ? -v : v;
   endfunction

   state_t                state, state_nx;
   logic [CNT_W-1:0]      count;

   logic [2*XLEN-1:0]     acc, acc_nx;
   logic [XLEN-1:0]       opb;
   logic [2:0]            op_q;
   logic                  neg_q;
   logic                  special;
   logic [ROB_ID_W-1:0]   tag_q;

   logic                  accept;
   logic                  finish;

   // operand preparation at accept
   logic                  a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0]       a_abs, b_abs;
   logic                  div_zero, div_ovf;
   logic [XLEN-1:0]       spec_res;
   logic                  neg_init;

   // shared step adder
   logic [XLEN:0]         add_a, add_b;
   logic                  add_cin;
   logic [XLEN+1:0]       sum;

   logic [2*XLEN-1:0]     prod;
   logic [XLEN-1:0]       step_res, fin_res;

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign accept    = rdy_in && !rob_clear && in_valid && (state == ST_IDLE);
   assign finish    = (state == ST_BUSY) && (special || (count == LAST));

   always_comb begin
      a_sgn    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
      b_sgn    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      a_neg    = a_sgn && r1_val[XLEN-1];
      b_neg    = b_sgn && r2_val[XLEN-1];
      a_abs    = cond_neg(r1_val, a_neg);
      b_abs    = cond_neg(r2_val, b_neg);
      div_zero = is_div_op(op) && (r2_val == '0);
      div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                 (r1_val == {1'b1, {(XLEN-1){1'b0}}}) && (r2_val == '1);
      spec_res = '0;
      if (div_zero)
         spec_res = op[1] ? r1_val : '1;
      else if (div_ovf)
         spec_res = op[1] ? '0 : r1_val;
      // Remainder takes the dividend's sign; quotient and product take the XOR.
      if (is_div_op(op) && op[1])
         neg_init = a_neg;
      else
         neg_init = a_neg ^ b_neg;
   end

   // Divide: trial-subtract the divisor from the shifted partial remainder
   // (add the inverted divisor with carry-in). Multiply: add the multiplicand
   // into the upper half when the current multiplier bit is set.
   always_comb begin
      if (is_div_op(op_q)) begin
         add_a   = acc[2*XLEN-1:XLEN-1];
         add_b   = ~{1'b0, opb};
         add_cin = 1'b1;
      end else begin
         add_a   = {1'b0, acc[2*XLEN-1:XLEN]};
         add_b   = {1'b0, opb};
         add_cin = 1'b0;
      end
      sum = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, add_cin};

      if (is_div_op(op_q)) begin
         // carry out set means no borrow: the divisor fits, quotient bit is 1
         if (sum[XLEN+1])
            acc_nx = {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         else
            acc_nx = {acc[2*XLEN-2:0], 1'b0};
      end else begin
         if (acc[0])
            acc_nx = {sum[XLEN:0], acc[XLEN-1:1]};
         else
            acc_nx = {1'b0, acc[2*XLEN-1:1]};
      end
   end

   always_comb begin
      prod = neg_q ? -acc_nx : acc_nx;
      case (op_q)
         OP_MUL:                       step_res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: step_res = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              step_res = cond_neg(acc_nx[XLEN-1:0], neg_q);
         default:                      step_res = cond_neg(acc_nx[2*XLEN-1:XLEN], neg_q);
      endcase
      // special cases preload their final answer into the low half
      fin_res = special ? acc[XLEN-1:0] : step_res;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (rdy_in) begin
         if (rob_clear) begin
            state_nx = ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: if (in_valid)  state_nx = ST_BUSY;
               ST_BUSY: if (finish)    state_nx = ST_DONE;
               ST_DONE: if (out_ready) state_nx = ST_IDLE;
               default:                state_nx = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         count      <= '0;
         out_res    <= '0;
         out_rob_id <= '0;
      end else if (rdy_in) begin
         if (rob_clear || accept) begin
            count <= '0;
         end else if (state == ST_BUSY) begin
            count <= count + CNT_W'(1);
            if (finish) begin
               out_res    <= fin_res;
               out_rob_id <= tag_q;
            end
         end
      end
   end

   // Datapath registers carry no reset; they are only observed in BUSY.
   always_ff @(posedge clk_in) begin
      if (rdy_in) begin
         if (accept) begin
            op_q    <= op;
            tag_q   <= in_rob_id;
            neg_q   <= neg_init;
            special <= div_zero || div_ovf;
            opb     <= b_abs;
            acc     <= {{XLEN{1'b0}}, (div_zero || div_ovf) ? spec_res : a_abs};
         end else if (state == ST_BUSY) begin
            acc <= acc_nx;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): a table of directed
// vectors, randomized operations against a 64-bit arithmetic reference
// model, and hand-written sequences for flush, stall, backpressure and reset.
module tb_muldiv_unit;

   localparam int XLEN = 32;
   localparam int RW   = 4;

   logic            clk_in = 1'b0;
   logic            rst_n_in;
   logic            rdy_in;
   logic            rob_clear;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      op;
   logic [XLEN-1:0] r1_val, r2_val;
   logic [RW-1:0]   in_rob_id;
   logic            out_valid;
   logic            out_ready;
   logic [RW-1:0]   out_rob_id;
   logic [XLEN-1:0] out_res;

   int n_chk  = 0;
   int n_pass = 0;

   muldiv_unit #(.XLEN(XLEN), .ROB_ID_W(RW)) dut (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .rdy_in     (rdy_in),
      .rob_clear  (rob_clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .r1_val     (r1_val),
      .r2_val     (r2_val),
      .in_rob_id  (in_rob_id),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_rob_id (out_rob_id),
      .out_res    (out_res)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
      logic [31:0] res;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference model: RISC-V M semantics via 64-bit arithmetic.
   function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      case (o)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      if (o[2] && b == 0) return 1;
      if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN;
   endfunction

   // Called 1 time unit after a rising edge with the unit idle; returns
   // 1 time unit after the accepting edge T.
   task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
      chk("in_ready_before_accept", in_ready, 1);
      op = o; r1_val = a; r2_val = b; in_rob_id = t; in_valid = 1'b1;
      @(posedge clk_in); #1;
      in_valid = 1'b0;
   endtask

   // Counts rising edges until out_valid, bounded.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk_in); #1;
         lat++;
      end
   endtask

   task automatic drain_check();
      @(posedge clk_in); #1;
      chk("drain_out_valid", out_valid, 0);
      chk("drain_in_ready", in_ready, 1);
   endtask

   vec_t tbl[14];
   int   lat, viol;
   logic [31:0] a, b, exp_r;
   logic [2:0]  o;
   logic [3:0]  t;

   initial begin
      tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 4'd5, 32'hFFFF_FFEB, 32};
      tbl[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 32'hFFFF_FFFE, 32};
      tbl[2]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 4'd2, 32'h4000_0000, 32};
      tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 32'hFFFF_FFFF, 32};
      tbl[4]  = '{3'd4, 32'd5,          32'd0,         4'd4, 32'hFFFF_FFFF, 1};
      tbl[5]  = '{3'd7, 32'd5,          32'd0,         4'd6, 32'd5,         1};
      tbl[6]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, 32'h8000_0000, 1};
      tbl[7]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 32'd0,         1};
      tbl[8]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         4'd9, 32'hFFFF_FFFD, 32};
      tbl[9]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         4'd10, 32'hFFFF_FFFF, 32};
      tbl[10] = '{3'd5, 32'd100,        32'd7,         4'd11, 32'd14,        32};
      tbl[11] = '{3'd7, 32'd100,        32'd7,         4'd12, 32'd2,         32};
      tbl[12] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         4'd13, 32'hFFFF_FFFB, 1};
      tbl[13] = '{3'd5, 32'd5,          32'd0,         4'd14, 32'hFFFF_FFFF, 1};

      rst_n_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; in_valid = 1'b0;
      op = 3'd0; r1_val = '0; r2_val = '0; in_rob_id = '0; out_ready = 1'b1;
      #2 rst_n_in = 1'b0;
      #1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_res", out_res, 0);
      chk("reset_out_rob_id", out_rob_id, 0);
      repeat (2) @(posedge clk_in);
      #3 rst_n_in = 1'b1;
      @(posedge clk_in); #1;

      // directed table
      for (int i = 0; i < 14; i++) begin
         start_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag);
         wait_done(lat);
         chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
         chk($sformatf("tbl%0d_res", i), out_res, tbl[i].res);
         chk($sformatf("tbl%0d_tag", i), out_rob_id, tbl[i].tag);
         drain_check();
      end

      // randomized against the reference model
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         t = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 20));
            3: a = 32'h8000_0000;
            default: ;
         endcase
         start_op(o, a, b, t);
         wait_done(lat);
         chk($sformatf("rnd%0d_op%0d_lat", i, o), lat, ref_lat(o, a, b));
         chk($sformatf("rnd%0d_op%0d_res", i, o), out_res, ref_res(o, a, b));
         chk($sformatf("rnd%0d_tag", i), out_rob_id, t);
         drain_check();
      end

      // flush mid-operation
      start_op(3'd0, 32'd1234, 32'd5678, 4'd3);
      repeat (9) @(posedge clk_in);
      #1;
      chk("flush_busy_in_ready", in_ready, 0);
      rob_clear = 1'b1;
      @(posedge clk_in); #1;
      rob_clear = 1'b0;
      chk("flush_out_valid", out_valid, 0);
      chk("flush_in_ready", in_ready, 1);
      viol = 0;
      repeat (30) begin
         @(posedge clk_in); #1;
         if (out_valid) viol++;
      end
      chk("flush_no_result", viol, 0);

      // rdy_in low for 5 cycles during BUSY
      start_op(3'd4, 32'hFFFF_F000, 32'd37, 4'd6);
      repeat (3) @(posedge clk_in);
      #1 rdy_in = 1'b0;
      repeat (5) @(posedge clk_in);
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 0);
      rdy_in = 1'b1;
      wait_done(lat);
      chk("stall_lat", lat + 8, 37);
      chk("stall_res", out_res, ref_res(3'd4, 32'hFFFF_F000, 32'd37));
      drain_check();

      // backpressure in DONE
      out_ready = 1'b0;
      exp_r = ref_res(3'd6, 32'hFFFF_FC18, 32'd7);
      start_op(3'd6, 32'hFFFF_FC18, 32'd7, 4'd9);
      wait_done(lat);
      chk("bp_lat", lat, 32);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk_in); #1;
         chk($sformatf("bp%0d_out_valid", k), out_valid, 1);
         chk($sformatf("bp%0d_res", k), out_res, exp_r);
         chk($sformatf("bp%0d_tag", k), out_rob_id, 9);
         chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
      end
      out_ready = 1'b1;
      drain_check();

      // asynchronous reset mid-BUSY
      start_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 4'd15);
      repeat (5) @(posedge clk_in);
      #3 rst_n_in = 1'b0;
      #1;
      chk("rst_mid_in_ready", in_ready, 1);
      chk("rst_mid_out_valid", out_valid, 0);
      chk("rst_mid_out_res", out_res, 0);
      chk("rst_mid_out_rob_id", out_rob_id, 0);
      @(posedge clk_in);
      #3 rst_n_in = 1'b1;
      viol = 0;
      repeat (40) begin
         @(posedge clk_in); #1;
         if (out_valid) viol++;
      end
      chk("rst_mid_no_result", viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
